booth_mul_4bit: RTL and testbench



---
 rtl/booth_mul_pkg.sv | 31 +++
 rtl/_4bits_add_sub.sv | 34 +++
 rtl/booth_mul_4bit.sv | 118 +++++++++++
 tb/tb_booth_mul_4bit.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/booth_mul_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier and its add/sub stage.
package booth_mul_pkg;

  localparam int WIDTH = 4;
  localparam int ITER  = 4;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    BOOTH_NOP,
    BOOTH_ADD,
    BOOTH_SUB
  } booth_op_e;

  // Radix-2 Booth recoding of the current multiplier bit pair {Q[0], q_m1}.
  function automatic booth_op_e booth_decode(input logic q0, input logic q_m1);
    booth_op_e op;
    unique case ({q0, q_m1})
      2'b01:   op = BOOTH_ADD;
      2'b10:   op = BOOTH_SUB;
      default: op = BOOTH_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/_4bits_add_sub.sv
// 4-bit ripple adder/subtractor: S = A + B when M=0, S = A - B when M=1.
// C is the carry out, V the signed overflow (carry into MSB xor carry out).
module _4bits_add_sub
  import booth_mul_pkg::*;
(
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             M,
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic             V
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   carry;

  // Subtraction is A + ~B + 1: invert B and inject the mode bit as carry-in.
  assign b_eff = B ^ {WIDTH{M}};

  always_comb begin
    // NOTE: every variable written here gets a value first, so no path can infer a latch.
    carry    = '0;
    S        = '0;
    carry[0] = M;
    for (int i = 0; i < WIDTH; i++) begin
      S[i]       = A[i] ^ b_eff[i] ^ carry[i];
      carry[i+1] = (A[i] & b_eff[i]) | (carry[i] & (A[i] ^ b_eff[i]));
    end
  end

  assign C = carry[WIDTH];
  assign V = carry[WIDTH] ^ carry[WIDTH-1];

endmodule

// File: rtl/booth_mul_4bit.sv
// Sequential 4x4 signed radix-2 Booth multiplier built around one 4-bit add/sub.
// One iteration per cycle; the 8-bit product {A,Q} is held in DONE until the next start.
module booth_mul_4bit
  import booth_mul_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  state_e state, next_state;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic             q_m1;
  logic [WIDTH-1:0] m;
  logic [CNT_W-1:0] cnt;

  logic load;
  logic iterate;
  logic last_iter;

  booth_op_e        op;
  logic             arith;
  logic             add_mode;
  logic [WIDTH-1:0] add_s;
  logic             add_v;
  logic             add_c_unused;
  logic [WIDTH-1:0] s_sel;
  logic             sign_t;

  // ---------------------------------------------------------------------------
  // Arithmetic element
  // ---------------------------------------------------------------------------
  assign op       = booth_decode(q[0], q_m1);
  assign arith    = (op != BOOTH_NOP);
  assign add_mode = (op == BOOTH_SUB);

  _4bits_add_sub u_add_sub (
    .A (acc),
    .B (m),
    .M (add_mode),
    .S (add_s),
    .C (add_c_unused),
    .V (add_v)
  );

  // The true sign of A+/-M survives overflow as S[3]^V; without it -8 x -8 goes wrong.
  assign s_sel  = arith ? add_s : acc;
  assign sign_t = arith ? (add_s[WIDTH-1] ^ add_v) : acc[WIDTH-1];

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  assign last_iter = (cnt == CNT_W'(ITER - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    iterate    = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          load       = 1'b1;
          next_state = CALC;
        end
      end
      CALC: begin
        iterate = 1'b1;
        if (last_iter) next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers: load on accept, arithmetic shift right each iteration
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      q    <= '0;
      q_m1 <= 1'b0;
      m    <= '0;
      cnt  <= '0;
    end else if (load) begin
      acc  <= '0;
      q    <= mplier;
      q_m1 <= 1'b0;
      m    <= mcand;
      cnt  <= '0;
    end else if (iterate) begin
      acc  <= {sign_t, s_sel[WIDTH-1:1]};
      q    <= {s_sel[0], q[WIDTH-1:1]};
      q_m1 <= q[0];
      cnt  <= cnt + CNT_W'(1);
    end
  end

  assign busy    = (state == CALC);
  assign done    = (state == DONE);
  assign product = {acc, q};

endmodule

// File: tb/tb_booth_mul_4bit.sv
// Directed self-checking bench for booth_mul_4bit with hand-computed products.
module tb_booth_mul_4bit;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] mcand;
  logic [3:0] mplier;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int checks = 0;
  int errors = 0;

  booth_mul_4bit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mcand   (mcand),
    .mplier  (mplier),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Accept at edge N, check busy across N..N+3, then done and product after N+4.
  // Operands are scrambled after acceptance to show they are not re-sampled.
  task automatic run_mul(input string tag, input logic [3:0] mc, input logic [3:0] mp,
                         input logic [7:0] exp_p);
    @(negedge clk);
    start  = 1'b1;
    mcand  = mc;
    mplier = mp;
    @(negedge clk);
    start  = 1'b0;
    mcand  = ~mc;
    mplier = mp + 4'd3;
    check({tag, " busy/done c1"}, {6'd0, busy, done}, 8'b10);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check({tag, " busy/done"}, {6'd0, busy, done}, 8'b10);
    end
    @(negedge clk);
    check({tag, " busy/done end"}, {6'd0, busy, done}, 8'b01);
    check({tag, " product"}, product, exp_p);
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    mcand  = 4'd0;
    mplier = 4'd0;
    #12;
    check("reset busy/done", {6'd0, busy, done}, 8'b00);
    check("reset product", product, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle busy/done", {6'd0, busy, done}, 8'b00);

    run_mul("3x2", 4'd3, 4'd2, 8'h06);
    repeat (3) @(negedge clk);
    check("done hold", {6'd0, busy, done}, 8'b01);
    check("product hold", product, 8'h06);

    run_mul("-8x-8", 4'b1000, 4'b1000, 8'h40);
    run_mul("-8x7", 4'b1000, 4'd7, 8'hC8);
    run_mul("7x-8", 4'd7, 4'b1000, 8'hC8);
    run_mul("0x-5", 4'd0, 4'b1011, 8'h00);
    run_mul("-1x-1", 4'b1111, 4'b1111, 8'h01);

    // start during CALC must be ignored
    @(negedge clk);
    start  = 1'b1;
    mcand  = 4'd3;
    mplier = 4'd2;
    @(negedge clk);
    mcand  = 4'd5;
    mplier = 4'd5;
    check("calc start busy", {6'd0, busy, done}, 8'b10);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("ignored start busy/done", {6'd0, busy, done}, 8'b01);
    check("ignored start product", product, 8'h06);
    run_mul("5x5 from done", 4'd5, 4'd5, 8'h19);

    // Back-to-back: start held high through DONE restarts on the next edge.
    @(negedge clk);
    start  = 1'b1;
    mcand  = 4'd2;
    mplier = 4'b1101;
    repeat (4) @(negedge clk);
    check("b2b first busy", {6'd0, busy, done}, 8'b10);
    @(negedge clk);
    check("b2b first done", {6'd0, busy, done}, 8'b01);
    check("b2b first product", product, 8'hFA);
    mcand  = 4'd4;
    mplier = 4'd3;
    @(negedge clk);
    start = 1'b0;
    check("b2b restart busy", {6'd0, busy, done}, 8'b10);
    repeat (4) @(negedge clk);
    check("b2b second done", {6'd0, busy, done}, 8'b01);
    check("b2b second product", product, 8'h0C);

    // Asynchronous reset during the second CALC cycle
    @(negedge clk);
    start  = 1'b1;
    mcand  = 4'd7;
    mplier = 4'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre-reset busy", {6'd0, busy, done}, 8'b10);
    rst_n = 1'b0;
    #1;
    check("mid reset busy/done", {6'd0, busy, done}, 8'b00);
    check("mid reset product", product, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("no done after reset", {6'd0, busy, done}, 8'b00);
    check("product after reset", product, 8'h00);
    run_mul("7x7", 4'd7, 4'd7, 8'h31);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
